// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing for a 5-stage datapath (IF/ID, ID/EX, EX/MEM, MEM/WR).
//   A shadow scoreboard follows the destination register of the instructions
//   in the EX, MEM and WB stages. From it the block derives:
//   - stall, bubble and flush controls for the stage registers;
//   - ALU operand forwarding selects;
//   - a saturating count of stall cycles.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   id_valid            IF/ID holds a real instruction
//   id_rs, id_rt        source registers of the ID instruction
//   id_uses_rt          ID instruction reads Rt
//   id_aw               destination register of the ID instruction
//   id_regwr            ID instruction writes the register file
//   id_memtoreg         ID instruction is a load
//   ex_redirect         taken branch / jr resolved in EX this cycle
//   pc_en, if_id_en     PC and IF/ID load enables (low while stalled)
//   if_id_flush         IF/ID becomes a nop on the next edge
//   id_ex_bubble        ID/EX loads a nop on the next edge
//   fwd_a, fwd_b        EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WR
//   stall_cnt           saturating stall-cycle counter
//
// Flow control
//   The ID instruction advances into EX on an edge only when id_valid=1 and
//   id_ex_bubble=0. pc_en and if_id_en act as the "ready" of the front end:
//   while they are low, IF and ID hold their contents and EX receives a nop.
//   A redirect always completes: the front end reloads and both IF/ID and
//   ID/EX are squashed.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_aw,
  input  logic                  id_regwr,
  input  logic                  id_memtoreg,
  input  logic                  ex_redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  // EX slot: producer fields plus the operands it reads.
  logic ex_v, ex_regwr, ex_memtoreg, ex_uses_rt;
  reg_t ex_aw, ex_rs, ex_rt;
  // MEM slot: memtoreg matters because a load result is not in EX/MEM ALUout.
  logic mem_v, mem_regwr, mem_memtoreg;
  reg_t mem_aw;
  // WB slot: by this stage every result is on Dw, so the type no longer matters.
  logic wb_v, wb_regwr;
  reg_t wb_aw;

  logic hazard, stall;
  logic ex_hit, mem_hit, wb_hit;

  // Register 0 is hardwired, so it never carries a dependency.
  function automatic logic writes(input logic v, input logic regwr,
                                  input reg_t aw, input reg_t r);
    return v && regwr && (aw == r) && (r != '0);
  endfunction

  always_comb begin
    ex_hit  = writes(ex_v, ex_regwr, ex_aw, id_rs) ||
              (id_uses_rt && writes(ex_v, ex_regwr, ex_aw, id_rt));
    mem_hit = writes(mem_v, mem_regwr, mem_aw, id_rs) ||
              (id_uses_rt && writes(mem_v, mem_regwr, mem_aw, id_rt));
    wb_hit  = writes(wb_v, wb_regwr, wb_aw, id_rs) ||
              (id_uses_rt && writes(wb_v, wb_regwr, wb_aw, id_rt));

    // With forwarding only a load in EX cannot be bypassed in time.
    if (FWD_EN) hazard = id_valid && ex_memtoreg && ex_hit;
    else        hazard = id_valid && (ex_hit || mem_hit || wb_hit);

    // A redirect discards the dependent ID instruction, so it wins.
    stall        = hazard && !ex_redirect;
    pc_en        = !stall;
    if_id_en     = !stall;
    if_id_flush  = ex_redirect;
    id_ex_bubble = stall || ex_redirect;
  end

  // Operand forwarding; MEM is the younger producer and takes priority.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      if (writes(mem_v, mem_regwr, mem_aw, ex_rs) && !mem_memtoreg) fwd_a = 2'b01;
      else if (writes(wb_v, wb_regwr, wb_aw, ex_rs))                fwd_a = 2'b10;
      if (ex_uses_rt) begin
        if (writes(mem_v, mem_regwr, mem_aw, ex_rt) && !mem_memtoreg) fwd_b = 2'b01;
        else if (writes(wb_v, wb_regwr, wb_aw, ex_rt))                fwd_b = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v <= 1'b0; ex_regwr <= 1'b0; ex_memtoreg <= 1'b0; ex_uses_rt <= 1'b0;
      ex_aw <= '0;  ex_rs <= '0;      ex_rt <= '0;
      mem_v <= 1'b0; mem_regwr <= 1'b0; mem_memtoreg <= 1'b0; mem_aw <= '0;
      wb_v <= 1'b0;  wb_regwr <= 1'b0;  wb_aw <= '0;
      stall_cnt <= '0;
    end else begin
      wb_v         <= mem_v;
      wb_regwr     <= mem_regwr;
      wb_aw        <= mem_aw;
      mem_v        <= ex_v;
      mem_regwr    <= ex_regwr;
      mem_memtoreg <= ex_memtoreg;
      mem_aw       <= ex_aw;
      if (id_valid && !id_ex_bubble) begin
        ex_v        <= 1'b1;
        ex_regwr    <= id_regwr;
        ex_memtoreg <= id_memtoreg;
        ex_uses_rt  <= id_uses_rt;
        ex_aw       <= id_aw;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
      end else begin
        ex_v <= 1'b0; ex_regwr <= 1'b0; ex_memtoreg <= 1'b0; ex_uses_rt <= 1'b0;
        ex_aw <= '0;  ex_rs <= '0;      ex_rt <= '0;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a table of per-cycle vectors for the
// forwarding configuration, then hand-written sequences for asynchronous
// reset, the no-forwarding configuration and counter saturation.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_uses_rt = 1'b0, id_regwr = 1'b0, id_memtoreg = 1'b0;
  logic       ex_redirect = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_aw = '0;

  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        nf_pc_en, nf_if_id_en, nf_if_id_flush, nf_id_ex_bubble;
  logic [1:0]  nf_fwd_a, nf_fwd_b;
  logic [15:0] nf_stall_cnt;

  logic        st_pc_en, st_if_id_en, st_if_id_flush, st_id_ex_bubble;
  logic [1:0]  st_fwd_a, st_fwd_b;
  logic [1:0]  st_stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_aw(id_aw), .id_regwr(id_regwr),
    .id_memtoreg(id_memtoreg), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt));

  hazard_controller #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_aw(id_aw), .id_regwr(id_regwr),
    .id_memtoreg(id_memtoreg), .ex_redirect(ex_redirect),
    .pc_en(nf_pc_en), .if_id_en(nf_if_id_en), .if_id_flush(nf_if_id_flush),
    .id_ex_bubble(nf_id_ex_bubble), .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b),
    .stall_cnt(nf_stall_cnt));

  hazard_controller #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_aw(id_aw), .id_regwr(id_regwr),
    .id_memtoreg(id_memtoreg), .ex_redirect(ex_redirect),
    .pc_en(st_pc_en), .if_id_en(st_if_id_en), .if_id_flush(st_if_id_flush),
    .id_ex_bubble(st_id_ex_bubble), .fwd_a(st_fwd_a), .fwd_b(st_fwd_b),
    .stall_cnt(st_stall_cnt));

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       ut;
    logic [4:0] aw;
    logic       wr, mt, redir;
    logic       pc, ifen, fl, bub;
    logic [1:0] fa, fb;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  vec_t v_nop, v_add3, v_sub4, v_lw8, v_add9;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ut, input logic [4:0] aw, input logic wr,
                              input logic mt, input logic redir, input logic pc,
                              input logic ifen, input logic fl, input logic bub,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.ut = ut; t.aw = aw; t.wr = wr; t.mt = mt;
    t.redir = redir; t.pc = pc; t.ifen = ifen; t.fl = fl; t.bub = bub;
    t.fa = fa; t.fb = fb; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid    = t.v;
    id_rs       = t.rs;
    id_rt       = t.rt;
    id_uses_rt  = t.ut;
    id_aw       = t.aw;
    id_regwr    = t.wr;
    id_memtoreg = t.mt;
    ex_redirect = t.redir;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(v_nop);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    // opcode-like shorthands: fields only, expected outputs unused
    v_nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    v_add3 = mk(1, 1, 2, 1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    v_sub4 = mk(1, 3, 5, 1, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    v_lw8  = mk(1, 1, 0, 0, 8, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    v_add9 = mk(1, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    //            v rs rt ut aw wr mt rd | pc if fl bb fa fb cnt
    tbl[0]  = mk(1, 1, 2, 1, 3, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0); // add r3,r1,r2
    tbl[1]  = mk(1, 3, 5, 1, 4, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0); // sub r4,r3,r5
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0); // sub in EX: fwd_a=01
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 2, 1, 3, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0); // add r3
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0); // nop
    tbl[6]  = mk(1, 7, 3, 1, 6, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0); // or r6,r7,r3
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 0); // or in EX: fwd_b=10
    tbl[8]  = mk(1, 1, 0, 0, 8, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0); // lw r8
    tbl[9]  = mk(1, 8, 1, 1, 9, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0); // add r9,r8,r1: stall
    tbl[10] = mk(1, 8, 1, 1, 9, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // held add proceeds
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 0, 1); // add in EX: fwd_a=10
    tbl[12] = mk(1, 1, 2, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // add r0,r1,r2
    tbl[13] = mk(1, 5, 0, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1); // lw r0
    tbl[14] = mk(1, 0, 0, 1, 10, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1); // add r10,r0,r0: no stall
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1); // r0 never forwarded
    tbl[16] = mk(1, 1, 0, 0, 8, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1); // lw r8
    tbl[17] = mk(1, 8, 1, 1, 9, 1, 0, 1,  1, 1, 1, 1, 0, 0, 1); // load-use + redirect
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1); // count unchanged
    tbl[19] = mk(1, 1, 2, 1, 3, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // add r3,r1,r2
    tbl[20] = mk(1, 4, 5, 1, 3, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // add r3,r4,r5
    tbl[21] = mk(1, 3, 3, 1, 7, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // sub r7,r3,r3
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 1); // MEM beats WB
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1);
    tbl[24] = mk(1, 1, 0, 0, 8, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1); // lw r8
    tbl[25] = mk(1, 2, 8, 0, 9, 1, 0, 0,  1, 1, 0, 0, 0, 0, 1); // addi: rt not read
    tbl[26] = mk(1, 1, 0, 0, 8, 1, 1, 0,  1, 1, 0, 0, 0, 0, 1); // lw r8
    tbl[27] = mk(1, 2, 8, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1); // sw r8: stall on rt
    tbl[28] = mk(1, 2, 8, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2); // sw proceeds
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2, 2); // sw in EX: fwd_b=10

    // ---- reset state ----
    drive(v_nop);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_flush", if_id_flush, 0);
    chk("rst_bubble", id_ex_bubble, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 1'b1;
    next_cycle();

    // ---- table-driven vectors, forwarding configuration ----
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d_pc_en", i), pc_en, tbl[i].pc);
      chk($sformatf("row%0d_if_id_en", i), if_id_en, tbl[i].ifen);
      chk($sformatf("row%0d_flush", i), if_id_flush, tbl[i].fl);
      chk($sformatf("row%0d_bubble", i), id_ex_bubble, tbl[i].bub);
      chk($sformatf("row%0d_fwd_a", i), fwd_a, tbl[i].fa);
      chk($sformatf("row%0d_fwd_b", i), fwd_b, tbl[i].fb);
      chk($sformatf("row%0d_cnt", i), stall_cnt, tbl[i].cnt);
      next_cycle();
    end

    // ---- asynchronous reset in the middle of a load-use stall ----
    drive(v_lw8);
    next_cycle();
    drive(v_add9);
    #2;
    chk("arst_pre_stall", pc_en, 0);
    rst = 1'b0;
    #1;
    chk("arst_pc_en", pc_en, 1);
    chk("arst_if_id_en", if_id_en, 1);
    chk("arst_flush", if_id_flush, 0);
    chk("arst_bubble", id_ex_bubble, 0);
    chk("arst_fwd_a", fwd_a, 0);
    chk("arst_fwd_b", fwd_b, 0);
    chk("arst_cnt", stall_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(v_lw8);
    next_cycle();                 // first edge after release loads lw into EX
    drive(v_add9);
    @(negedge clk);
    chk("arst_release_stall", pc_en, 0);
    chk("arst_release_bubble", id_ex_bubble, 1);
    next_cycle();
    @(negedge clk);
    chk("arst_release_cnt", stall_cnt, 1);

    // ---- no-forwarding configuration: add r3 ; sub r4,r3,r5 ----
    do_reset();
    drive(v_add3);
    @(negedge clk);
    chk("nofwd_add_pc_en", nf_pc_en, 1);
    next_cycle();
    drive(v_sub4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("nofwd_stall%0d_pc_en", k), nf_pc_en, 0);
      chk($sformatf("nofwd_stall%0d_if_id_en", k), nf_if_id_en, 0);
      chk($sformatf("nofwd_stall%0d_bubble", k), nf_id_ex_bubble, 1);
      chk($sformatf("nofwd_stall%0d_fwd_a", k), nf_fwd_a, 0);
      chk($sformatf("nofwd_stall%0d_fwd_b", k), nf_fwd_b, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("nofwd_release_pc_en", nf_pc_en, 1);
    chk("nofwd_release_bubble", nf_id_ex_bubble, 0);
    chk("nofwd_cnt", nf_stall_cnt, 3);
    next_cycle();
    drive(v_nop);
    @(negedge clk);
    chk("nofwd_ex_fwd_a", nf_fwd_a, 0);
    next_cycle();

    // ---- saturation of a 2-bit counter over 5 load-use stalls ----
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(v_lw8);
      next_cycle();
      drive(v_add9);
      @(negedge clk);
      chk($sformatf("sat%0d_stall", k), st_pc_en, 0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", k), st_stall_cnt, (k + 1 > 3) ? 3 : k + 1);
      next_cycle();
    end
    drive(v_nop);
    @(negedge clk);
    chk("sat_final_cnt", st_stall_cnt, 3);
    chk("wide_final_cnt", stall_cnt, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
